// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants for the ID/EX pipeline register slice
//
// Purpose: id_ctrl bit positions, control-word width, FSM state encoding and a
//          helper that sanitises the captured control word.
// Ports:   none (package).
package pipeline_pkg;

    localparam int CTRL_W = 10;

    // id_ctrl = {alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
    localparam int CTRL_BRANCH     = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_ALU_OP_LO  = 6;
    localparam int CTRL_ALU_OP_HI  = 9;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // x0 is hard-wired zero, so an instruction targeting it must never look
    // like a register writer to forwarding or writeback.
    function automatic ctrl_t sanitize_ctrl(input ctrl_t ctrl, input logic [4:0] rd);
        ctrl_t c;
        c = ctrl;
        if (rd == 5'd0) begin
            c[CTRL_REG_WRITE] = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - combinational load-use hazard detector
//
// Purpose: flags an instruction in ID that reads the destination of a load
//          currently sitting in ID/EX.
// Ports:
//   idex_valid, idex_mem_read, idex_rd : load candidate in ID/EX
//   id_valid, id_rs1, id_rs2           : consumer candidate in ID
//   load_use                           : hazard present this cycle
module hazard_detect_unit (
    input  logic       idex_valid,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    always_comb begin
        load_use = idex_valid & idex_mem_read & (idex_rd != 5'd0)
                 & ((idex_rd == id_rs1) | (idex_rd == id_rs2)) & id_valid;
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble and EX hold
//
// Purpose: registers the ID-stage instruction into the EX view, inserting a
//          single bubble on a load-use hazard, freezing while the EX unit is
//          busy and squashing on a taken-branch flush.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   id_valid, id_pc, id_rs1_data,
//   id_rs2_data, id_imm, id_rs1,
//   id_rs2, id_rd, id_ctrl       : ID-stage instruction
//   flush                        : taken branch resolved in EX
//   ex_busy                      : EX unit cannot accept a new instruction
//   idex_*                       : registered EX-stage view
//   stall                        : freeze PC and IF/ID (combinational)
//   bubble_count                 : bubbles inserted, saturating
//                                  (only with HAZARD_STATS_EN defined)
module id_ex_stage
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_busy,
    output logic              idex_valid,
    output logic [31:0]       idex_pc,
    output logic [31:0]       idex_rs1_data,
    output logic [31:0]       idex_rs2_data,
    output logic [31:0]       idex_imm,
    output logic [4:0]        idex_rs1,
    output logic [4:0]        idex_rs2,
    output logic [4:0]        idex_rd,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       bubble_count
`endif
);

    logic [1:0] state;
    logic       load_use;
    logic       do_bubble;

    hazard_detect_unit u_hazard (
        .idex_valid    (idex_valid),
        .idex_mem_read (idex_ctrl[CTRL_MEM_READ]),
        .idex_rd       (idex_rd),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .load_use      (load_use)
    );

    // A bubble leaves idex_valid low, so a hazard cannot reappear in the
    // BUBBLE state; gating on state makes "one bubble per load" explicit.
    always_comb begin
        do_bubble = load_use & (state != ST_BUBBLE);
        stall     = ~rst & ~flush & (ex_busy | do_bubble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            idex_valid    <= 1'b0;
            idex_pc       <= '0;
            idex_rs1_data <= '0;
            idex_rs2_data <= '0;
            idex_imm      <= '0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_ctrl     <= '0;
        end else if (flush) begin
            state      <= ST_RUN;
            idex_valid <= 1'b0;
            idex_ctrl  <= '0;
        end else if (ex_busy) begin
            state <= ST_HOLD;
        end else if (do_bubble) begin
            state      <= ST_BUBBLE;
            idex_valid <= 1'b0;
            idex_ctrl  <= '0;
        end else begin
            state         <= ST_RUN;
            idex_valid    <= id_valid;
            idex_pc       <= id_pc;
            idex_rs1_data <= id_rs1_data;
            idex_rs2_data <= id_rs2_data;
            idex_imm      <= id_imm;
            idex_rs1      <= id_rs1;
            idex_rs2      <= id_rs2;
            idex_rd       <= id_rd;
            idex_ctrl     <= sanitize_ctrl(id_ctrl, id_rd);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (!flush && !ex_busy && do_bubble && (bubble_count != 32'hFFFF_FFFF)) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule
